// File: rtl/lib_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : lib_rr_arb
//  Description : Burst-granular round-robin arbiter. A one-hot base pointer
//                seeds a wrapping find-first-set search over the request
//                vector. The winner keeps the grant until end of burst,
//                withdrawal, or a MAX_BEATS beat timeout. The pointer then
//                moves to the requester just above the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module lib_rr_arb #(
    parameter int N_REQ     = 4,
    parameter int MAX_BEATS = 16,
    parameter int IDX_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    input  logic             ack,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout
);

    localparam int         CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BEATS - 1);

    logic [0:0]       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_timeout;
    logic [N_REQ-1:0] r_base;
    logic [CNT_W-1:0] r_beat_cnt;

    logic [N_REQ-1:0] w_req_hi;
    logic [N_REQ-1:0] w_pick;
    logic [IDX_W-1:0] w_win_idx;
    logic [N_REQ-1:0] w_win_onehot;
    logic             w_end_burst;
    logic             w_withdraw;
    logic             w_beat_limit;
    logic             w_release;
    logic             w_timeout_rel;

    // Wrapping priority search: requests at or above the base bit first,
    // otherwise fall back to the lowest request overall.
    always_comb begin
        w_req_hi     = req & ~(r_base - N_REQ'(1));
        w_pick       = (w_req_hi != '0) ? w_req_hi : req;
        w_win_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                w_win_idx = IDX_W'(i);
            end
        end
        w_win_onehot = N_REQ'(1) << w_win_idx;
    end

    // Release decode for the current grantee; a timeout pulse is reported
    // only when neither end-of-burst nor withdrawal explains the release.
    always_comb begin
        w_end_burst   = ack && last[r_gnt_idx];
        w_withdraw    = !req[r_gnt_idx];
        w_beat_limit  = ack && (r_beat_cnt == c_last_beat) && !last[r_gnt_idx];
        w_release     = w_end_burst || w_withdraw || w_beat_limit;
        w_timeout_rel = w_beat_limit && !w_withdraw;
    end

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_timeout  <= 1'b0;
            r_base     <= N_REQ'(1);
            r_beat_cnt <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req != '0) begin
                        r_state    <= S_GRANT;
                        r_gnt      <= w_win_onehot;
                        r_gnt_idx  <= w_win_idx;
                        r_beat_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state    <= S_IDLE;
                        r_gnt      <= '0;
                        r_gnt_idx  <= '0;
                        r_beat_cnt <= '0;
                        r_base     <= {r_gnt[N_REQ-2:0], r_gnt[N_REQ-1]};
                        r_timeout  <= w_timeout_rel;
                    end else if (ack) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = |r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_lib_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lib_rr_arb
//  Description : Scoreboard bench for lib_rr_arb. A cycle-level ownership
//                model predicts the outputs after each edge and queues them;
//                a monitor pops and compares after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lib_rr_arb;

    localparam int N   = 4;
    localparam int MAX = 16;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         ack;
    logic [N-1:0] gnt;
    logic         gnt_vld;
    logic [1:0]   gnt_idx;
    logic         timeout;

    lib_rr_arb #(.N_REQ(N), .MAX_BEATS(MAX)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .last    (last),
        .ack     (ack),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic         vld;
        logic [1:0]   idx;
        logic         to;
    } exp_t;

    exp_t q_exp[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_cycle  = 0;
    int n_to     = 0;

    // Model: who owns the resource, where the search starts, beats taken.
    int m_owner = -1;
    int m_start = 0;
    int m_beats = 0;
    logic m_to  = 1'b0;

    task automatic chk(input string name, input int act, input int req_v);
        n_checks++;
        if (act == req_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, n_cycle, act, req_v);
        end
    endtask

    task automatic model_step(input logic rn, input logic [N-1:0] r,
                              input logic [N-1:0] l, input logic a);
        int o;
        int nb;
        exp_t e;
        m_to = 1'b0;
        if (!rn) begin
            m_owner = -1;
            m_start = 0;
            m_beats = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_start + k) % N]) begin
                    m_owner = (m_start + k) % N;
                    m_beats = 0;
                end
            end
        end else begin
            o  = m_owner;
            nb = m_beats + (a ? 1 : 0);
            if ((a && l[o]) || !r[o]) begin
                m_owner = -1;
                m_start = (o + 1) % N;
            end else if (a && nb == MAX) begin
                m_owner = -1;
                m_start = (o + 1) % N;
                m_to    = 1'b1;
            end else begin
                m_beats = nb;
            end
        end
        e.gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.vld = (m_owner >= 0);
        e.idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.to  = m_to;
        q_exp.push_back(e);
    endtask

    task automatic cyc(input logic rn, input logic [N-1:0] r,
                       input logic [N-1:0] l, input logic a);
        @(negedge clk);
        rstn = rn;
        req  = r;
        last = l;
        ack  = a;
        model_step(rn, r, l, a);
    endtask

    // Monitor: compare DUT outputs after each edge against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_cycle++;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("gnt",     int'(gnt),     int'(e.gnt));
                chk("gnt_vld", int'(gnt_vld), int'(e.vld));
                chk("gnt_idx", int'(gnt_idx), int'(e.idx));
                chk("timeout", int'(timeout), int'(e.to));
                if (timeout) n_to++;
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        rstn = 1'b0;
        req  = '0;
        last = '0;
        ack  = 1'b0;

        // Reset, then two requesters with 1-beat bursts.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'b0110, 4'b1111, 1'b1);

        // All requesting, 1-beat bursts: full rotation with wrap.
        for (int i = 0; i < 12; i++) cyc(1'b1, 4'b1111, 4'b1111, 1'b1);

        // Single requester never ends its burst: forced release, regrant.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 4'b0001, 4'b0000, 1'b1);

        // Grantee 2 withdraws; requester 3 must win over 0 afterwards.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0100, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0100, 4'b0000, 1'b0);
        cyc(1'b1, 4'b1001, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1001, 4'b0000, 1'b0);

        // Reset mid-burst on requester 1, then 0 wins.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0010, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0010, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0010, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0011, 4'b0000, 1'b0);

        // 16th beat coincides with last: normal release, no timeout.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0001, 4'b0000, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b1, 4'b0001, 4'b0000, 1'b1);
        cyc(1'b1, 4'b0001, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, 4'b0000, 1'b0);

        // Randomized traffic with sticky requests and rare end-of-burst.
        r = '0;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
            end
            cyc(($urandom_range(0, 599) != 0), r,
                N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)) &
                N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0));
        end

        cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #3;
        chk("queue_drained", q_exp.size(), 0);
        chk("timeouts_seen", int'(n_to > 1), 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
